// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared sizing constants for the register scoreboard
package reg_scoreboard_pkg;
  localparam int SB_NUM_REGS = 32;
  localparam int SB_ADDR_W   = 5;
  localparam int SB_LAT_W    = 3;
endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// rtl/reg_scoreboard_sb_entry.sv - one per-register latency countdown (near port with SCOREBOARD_FWD_EN)
module reg_scoreboard_sb_entry
  import reg_scoreboard_pkg::*;
#(
  parameter int LAT_W = SB_LAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
`ifdef SCOREBOARD_FWD_EN
  output logic             near,
`endif
  output logic             busy
);

  logic [LAT_W-1:0] cnt;

  // Countdown: reset/clear first, then a fresh load beats the decrement, then count down to 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  assign busy = (cnt != '0);
`ifdef SCOREBOARD_FWD_EN
  // One cycle out: the result can be forwarded to a reader issuing now.
  assign near = (cnt == LAT_W'(1));
`endif

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - issue-stage RAW/WAW scoreboard; SCOREBOARD_FWD_EN enables forwarding-aware RAW check
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = SB_NUM_REGS,
  parameter int ADDR_W   = SB_ADDR_W,
  parameter int LAT_W    = SB_LAT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   rs_add,
  input  logic [ADDR_W-1:0]   rt_add,
  input  logic [ADDR_W-1:0]   rd_add,
  input  logic                uses_rs,
  input  logic                uses_rt,
  input  logic                writes_rd,
  input  logic [LAT_W-1:0]    lat,
  output logic                stall,
  output logic                issue_accept,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                any_busy
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] blk;
  logic [LAT_W-1:0]    lat_eff;

  // A zero latency still needs one cycle before the result is usable.
  assign lat_eff = (lat == '0) ? LAT_W'(1) : lat;

  // Register 0 is hard-wired and never has a pending write.
  assign busy[0] = 1'b0;

`ifdef SCOREBOARD_FWD_EN
  logic [NUM_REGS-1:0] near;
  assign near[0] = 1'b0;
  // Sources one cycle from ready are covered by the bypass network.
  assign blk = busy & ~near;
`else
  assign blk = busy;
`endif

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    logic ld;
    assign ld = issue_accept & writes_rd & (rd_add == ADDR_W'(i));
    reg_scoreboard_sb_entry #(.LAT_W(LAT_W)) u_entry (
      .clk      (clk),
      .rst      (rst),
      .clear    (flush),
      .load     (ld),
      .load_val (lat_eff),
`ifdef SCOREBOARD_FWD_EN
      .near     (near[i]),
`endif
      .busy     (busy[i])
    );
  end

  // Hazard detection: RAW on either used source, WAW on the destination.
  always_comb begin
    stall = issue_valid & ~flush &
            ((uses_rs & blk[rs_add]) | (uses_rt & blk[rt_add]) | (writes_rd & busy[rd_add]));
    issue_accept = issue_valid & ~stall & ~flush;
  end

  assign busy_mask = busy;
  assign any_busy  = |busy;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - self-checking bench for reg_scoreboard (honours SCOREBOARD_FWD_EN)
module tb_reg_scoreboard;

`ifdef SCOREBOARD_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, issue_valid;
  logic [4:0]  rs_add, rt_add, rd_add;
  logic        uses_rs, uses_rt, writes_rd;
  logic [2:0]  lat;
  logic        stall, issue_accept, any_busy;
  logic [31:0] busy_mask;

  int total = 0;
  int bad   = 0;
  bit armed = 0;

  // Model state: remaining cycles until each register's result is usable.
  int mcnt [32];

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid),
    .rs_add(rs_add), .rt_add(rt_add), .rd_add(rd_add),
    .uses_rs(uses_rs), .uses_rt(uses_rt), .writes_rd(writes_rd), .lat(lat),
    .stall(stall), .issue_accept(issue_accept), .busy_mask(busy_mask), .any_busy(any_busy)
  );

  function automatic bit m_blk(int r);
    if (FWD != 0) return (mcnt[r] > 1);
    return (mcnt[r] > 0);
  endfunction

  function automatic bit m_stall();
    if (!issue_valid || flush) return 0;
    return (uses_rs && m_blk(int'(rs_add))) || (uses_rt && m_blk(int'(rt_add))) ||
           (writes_rd && mcnt[int'(rd_add)] > 0);
  endfunction

  function automatic bit m_accept();
    return issue_valid && !flush && !m_stall();
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    m = '0;
    for (int r = 0; r < 32; r++) m[r] = (mcnt[r] > 0);
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each active edge from the inputs applied during the cycle.
  always @(posedge clk) begin
    bit acc;
    acc = m_accept();
    for (int r = 0; r < 32; r++) begin
      if (rst || flush) mcnt[r] = 0;
      else if (acc && writes_rd && r != 0 && int'(rd_add) == r) mcnt[r] = (lat == 0) ? 1 : int'(lat);
      else if (mcnt[r] > 0) mcnt[r] = mcnt[r] - 1;
    end
  end

  // Cycle-by-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (armed) begin
      check("m_stall", {31'b0, stall}, {31'b0, m_stall()});
      check("m_accept", {31'b0, issue_accept}, {31'b0, m_accept()});
      check("m_mask", busy_mask, m_mask());
      check("m_any", {31'b0, any_busy}, {31'b0, |m_mask()});
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; flush = 0; uses_rs = 0; uses_rt = 0; writes_rd = 0;
    rs_add = 0; rt_add = 0; rd_add = 0; lat = 0;
  endtask

  task automatic put(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                     input logic [4:0] rd, input logic wrd, input logic [2:0] l);
    idle();
    issue_valid = 1; rs_add = rs; uses_rs = urs; rt_add = rt; uses_rt = urt;
    rd_add = rd; writes_rd = wrd; lat = l;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    idle();
    rst = 1;
    // 1: reset two cycles, then idle
    next();
    armed = 1;
    next();
    rst = 0;
    mid();
    check("rst_mask", busy_mask, 32'h0);
    check("rst_any", {31'b0, any_busy}, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_acc", {31'b0, issue_accept}, 32'h0);

    // 2/3: producer rd=5 lat=3, dependent reader on rs
    next();
    put(0, 0, 0, 0, 5, 1, 3);
    mid();
    check("prod_acc", {31'b0, issue_accept}, 32'h1);
    for (int k = 1; k <= 4; k++) begin
      next();
      put(5, 1, 0, 0, 0, 0, 0);
      mid();
      if (k == 1) check("raw_mask", busy_mask, 32'h20);
      check($sformatf("raw_stall_t%0d", k), {31'b0, stall}, (k <= 3 - FWD) ? 32'h1 : 32'h0);
      check($sformatf("raw_acc_t%0d", k), {31'b0, issue_accept}, (k <= 3 - FWD) ? 32'h0 : 32'h1);
      if (issue_accept) break;
    end
    next(); idle(); next(); next();

    // rt-only dependency; rs busy but unused must not stall
    put(0, 0, 0, 0, 12, 1, 2);
    next();
    put(12, 0, 0, 0, 0, 0, 0);
    mid();
    check("rs_unused", {31'b0, stall}, 32'h0);
    next();
    put(0, 0, 12, 1, 0, 0, 0);
    mid();
    check("rt_raw", {31'b0, stall}, (FWD != 0) ? 32'h0 : 32'h1);
    next(); idle(); next(); next();

    // 4: rd=0 never busy; lat=0 behaves as 1
    put(0, 0, 0, 0, 0, 1, 7);
    next(); idle();
    mid();
    check("rd0_mask", busy_mask, 32'h0);
    next();
    put(0, 0, 0, 0, 9, 1, 0);
    next(); idle();
    mid();
    check("lat0_busy", busy_mask, 32'h200);
    check("lat0_any", {31'b0, any_busy}, 32'h1);
    next();
    mid();
    check("lat0_clear", busy_mask, 32'h0);

    // 5: WAW on rd=7 with cnt=4
    next();
    put(0, 0, 0, 0, 7, 1, 4);
    for (int k = 1; k <= 5; k++) begin
      next();
      put(0, 0, 0, 0, 7, 1, 2);
      mid();
      check($sformatf("waw_stall_t%0d", k), {31'b0, stall}, (k <= 4) ? 32'h1 : 32'h0);
    end
    next(); idle(); next(); next(); next();

    // 6: flush with pending regs 3,4,31 and a concurrent issue
    put(0, 0, 0, 0, 3, 1, 7);
    next(); put(0, 0, 0, 0, 4, 1, 7);
    next(); put(0, 0, 0, 0, 31, 1, 5);
    next(); put(0, 0, 0, 0, 10, 1, 3);
    flush = 1;
    mid();
    check("fl_mask_pre", busy_mask, 32'h8000_0018);
    check("fl_acc", {31'b0, issue_accept}, 32'h0);
    check("fl_stall", {31'b0, stall}, 32'h0);
    next(); idle();
    mid();
    check("fl_mask", busy_mask, 32'h0);
    check("fl_any", {31'b0, any_busy}, 32'h0);

    // reset also clears pending writes
    next();
    put(0, 0, 0, 0, 20, 1, 6);
    next(); idle(); rst = 1;
    next(); rst = 0;
    mid();
    check("rst2_mask", busy_mask, 32'h0);
    next(); next();

    armed = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
